alu: RTL and testbench

Combinational 16-bit arithmetic/logic unit with a registered 4-bit condition-flag file, instantiated inside the execute stage of the Dioptase simple pipeline. Execute muxes operands (register, forwarded or immediate) into `lhs`/`rhs`, uses `result` as both ALU result and memory address, and evaluates branch conditions against `flags`. Flags hold the outcome of the most recent non-bubbled ALU-class instruction.

---
 rtl/alu.sv | 197 +++++++++++++++++++
 tb/tb_alu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 16-bit ALU for the execute stage: combinational result, registered {V,N,Z,C} flag file.
// Flags update only for non-bubbled ALU-class opcodes; C feeds back as carry-in for addc/subb.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  opcode,
  input  logic [3:0]  alu_op,
  input  logic [15:0] lhs,
  input  logic [15:0] rhs,
  input  logic        bubble,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    OPC_ALU_RR = 3'b000,
    OPC_ALU_RI = 3'b001,
    OPC_RSVD   = 3'b010,
    OPC_LUI    = 3'b011,
    OPC_STORE  = 3'b100,
    OPC_LOAD   = 3'b101,
    OPC_BRANCH = 3'b110,
    OPC_JALR   = 3'b111
  } opcode_e;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_NAND = 4'd1,
    OP_OR   = 4'd2,
    OP_NOR  = 4'd3,
    OP_XOR  = 4'd4,
    OP_XNOR = 4'd5,
    OP_NOT  = 4'd6,
    OP_SHL  = 4'd7,
    OP_SHR  = 4'd8,
    OP_SAR  = 4'd9,
    OP_ROTL = 4'd10,
    OP_ROTR = 4'd11,
    OP_ADD  = 4'd12,
    OP_ADDC = 4'd13,
    OP_SUB  = 4'd14,
    OP_SUBB = 4'd15
  } alu_op_e;

  // Full adder shared by add/addc/sub/subb; subtraction arrives with b already inverted.
  function automatic logic [DATA_W:0] add_carry(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              cin
  );
    return {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
  endfunction

  function automatic logic add_overflow(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Returns {carry_out, result}. Shifting into a double-width window leaves the last
  // bit shifted out sitting next to the result, so amount 0 yields carry 0 for free.
  function automatic logic [DATA_W:0] shift_unit(
    input alu_op_e           op,
    input logic [DATA_W-1:0] a,
    input logic [3:0]        amt
  );
    logic        [2*DATA_W-1:0] w;
    logic signed [2*DATA_W-1:0] ws;
    logic        [DATA_W-1:0]   res;
    logic                       c;
    w   = '0;
    ws  = '0;
    res = a;
    c   = 1'b0;
    case (op)
      OP_SHL: begin
        w   = {{DATA_W{1'b0}}, a} << amt;
        res = w[DATA_W-1:0];
        c   = w[DATA_W];
      end
      OP_SHR: begin
        w   = {a, {DATA_W{1'b0}}} >> amt;
        res = w[2*DATA_W-1:DATA_W];
        c   = w[DATA_W-1];
      end
      OP_SAR: begin
        ws  = {a, {DATA_W{1'b0}}};
        ws  = ws >>> amt;
        res = ws[2*DATA_W-1:DATA_W];
        c   = ws[DATA_W-1];
      end
      OP_ROTL: begin
        w   = {a, a} << amt;
        res = w[2*DATA_W-1:DATA_W];
        c   = (amt != 4'd0) ? res[0] : 1'b0;
      end
      OP_ROTR: begin
        w   = {a, a} >> amt;
        res = w[DATA_W-1:0];
        c   = (amt != 4'd0) ? res[DATA_W-1] : 1'b0;
      end
      default: begin
        res = a;
        c   = 1'b0;
      end
    endcase
    return {c, res};
  endfunction

  logic [3:0]        r_flags;
  opcode_e           w_opc;
  alu_op_e           w_op;
  logic              w_is_alu;
  logic              w_is_sub;
  logic              w_cin;
  logic [DATA_W-1:0] w_b_op;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_addr;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_c;
  logic              w_alu_v;
  logic [3:0]        w_next_flags;
  logic              w_flag_we;

  assign w_opc    = opcode_e'(opcode);
  assign w_op     = alu_op_e'(alu_op);
  assign w_is_alu = (w_opc == OPC_ALU_RR) || (w_opc == OPC_ALU_RI);
  assign w_is_sub = (w_op == OP_SUB) || (w_op == OP_SUBB);

  always_comb begin
    w_cin = 1'b0;
    case (w_op)
      OP_ADDC, OP_SUBB: w_cin = r_flags[0];
      OP_SUB:           w_cin = 1'b1;
      default:          w_cin = 1'b0;
    endcase
  end

  assign w_b_op  = w_is_sub ? ~rhs : rhs;
  assign w_sum   = add_carry(lhs, w_b_op, w_cin);
  assign w_shift = shift_unit(w_op, lhs, rhs[3:0]);
  assign w_addr  = add_carry(lhs, rhs, 1'b0);

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (w_op)
      OP_AND:  w_alu_res = lhs & rhs;
      OP_NAND: w_alu_res = ~(lhs & rhs);
      OP_OR:   w_alu_res = lhs | rhs;
      OP_NOR:  w_alu_res = ~(lhs | rhs);
      OP_XOR:  w_alu_res = lhs ^ rhs;
      OP_XNOR: w_alu_res = ~(lhs ^ rhs);
      OP_NOT:  w_alu_res = ~rhs;
      OP_SHL, OP_SHR, OP_SAR, OP_ROTL, OP_ROTR: begin
        w_alu_res = w_shift[DATA_W-1:0];
        w_alu_c   = w_shift[DATA_W];
      end
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBB: begin
        w_alu_res = w_sum[DATA_W-1:0];
        w_alu_c   = w_sum[DATA_W];
        w_alu_v   = add_overflow(lhs[DATA_W-1], w_b_op[DATA_W-1], w_sum[DATA_W-1]);
      end
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    result = w_addr[DATA_W-1:0];
    case (w_opc)
      OPC_ALU_RR, OPC_ALU_RI: result = w_alu_res;
      OPC_LUI:                result = lhs;
      default:                result = w_addr[DATA_W-1:0];
    endcase
  end

  assign w_next_flags = {w_alu_v, w_alu_res[DATA_W-1], (w_alu_res == '0), w_alu_c};
  assign w_flag_we    = w_is_alu && !bubble;

  // Flag register stage: holds the outcome of the last committed ALU-class instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (w_flag_we) begin
      r_flags <= w_next_flags;
    end
  end

  assign flags = r_flags;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected result/flags from a behavioural model,
// a monitor pops and compares each cycle; reset behaviour is checked directly.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [2:0]  opcode;
  logic [3:0]  alu_op;
  logic [15:0] lhs;
  logic [15:0] rhs;
  logic        bubble;
  logic [15:0] result;
  logic [3:0]  flags;

  alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .alu_op (alu_op),
    .lhs    (lhs),
    .rhs    (rhs),
    .bubble (bubble),
    .result (result),
    .flags  (flags)
  );

  typedef struct {
    int          id;
    logic [15:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t        q[$];
  logic [3:0]  m_flags;
  int          n_tests;
  int          n_fail;
  int          next_id;
  bit          mon_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Reference model: arithmetic on plain integers, shifts one bit at a time.
  task automatic model(input logic [2:0] op, input logic [3:0] aop, input logic [15:0] l,
                       input logic [15:0] r, input logic cin, output logic [15:0] res,
                       output logic [3:0] nf, output logic we);
    logic [15:0] v;
    logic        c;
    logic        ov;
    int          u;
    int          s;
    int          ci;
    res = 16'h0; nf = 4'h0; we = 1'b0; c = 1'b0; ov = 1'b0;
    if (op == 3'b000 || op == 3'b001) begin
      we = 1'b1;
      case (aop)
        4'd0: res = l & r;
        4'd1: res = ~(l & r);
        4'd2: res = l | r;
        4'd3: res = ~(l | r);
        4'd4: res = l ^ r;
        4'd5: res = ~(l ^ r);
        4'd6: res = ~r;
        4'd7, 4'd8, 4'd9, 4'd10, 4'd11: begin
          v = l;
          for (int i = 0; i < int'(r[3:0]); i++) begin
            case (aop)
              4'd7:    begin c = v[15]; v = {v[14:0], 1'b0}; end
              4'd8:    begin c = v[0];  v = {1'b0, v[15:1]}; end
              4'd9:    begin c = v[0];  v = {v[15], v[15:1]}; end
              4'd10:   begin c = v[15]; v = {v[14:0], v[15]}; end
              default: begin c = v[0];  v = {v[0], v[15:1]}; end
            endcase
          end
          res = v;
        end
        default: begin
          ci = (aop == 4'd12) ? 0 : (aop == 4'd14) ? 1 : int'(cin);
          if (aop == 4'd12 || aop == 4'd13) begin
            u = int'(l) + int'(r) + ci;
            s = int'($signed(l)) + int'($signed(r)) + ci;
          end else begin
            u = int'(l) + (65535 - int'(r)) + ci;
            s = int'($signed(l)) - int'($signed(r)) - 1 + ci;
          end
          res = u[15:0];
          c   = (u > 65535);
          ov  = (s > 32767) || (s < -32768);
        end
      endcase
      nf = {ov, res[15], res == 16'h0, c};
    end else if (op == 3'b011) begin
      res = l;
    end else begin
      res = l + r;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] aop, input logic [15:0] l,
                      input logic [15:0] r, input logic b);
    logic [15:0] res;
    logic [3:0]  nf;
    logic        we;
    exp_t        e;
    @(posedge clk);
    #2;
    opcode = op; alu_op = aop; lhs = l; rhs = r; bubble = b;
    model(op, aop, l, r, m_flags[0], res, nf, we);
    if (we && !b) m_flags = nf;
    e.id = next_id; e.res = res; e.flg = m_flags;
    q.push_back(e);
    next_id++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q.size() != 0 || mon_busy); i++) @(posedge clk);
    #2;
    if (q.size() != 0 || mon_busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    exp_t e;
    mon_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_busy = 1'b1;
        e = q.pop_front();
        check("result", e.id, result, e.res);
        @(posedge clk);
        #1;
        check("flags", e.id, {12'h0, flags}, {12'h0, e.flg});
        mon_busy = 1'b0;
      end
    end
  end

  function automatic logic [15:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    n_tests = 0; n_fail = 0; next_id = 0; m_flags = 4'h0;
    rst_n = 1'b0; opcode = 3'h0; alu_op = 4'h0; lhs = 16'h0; rhs = 16'h0; bubble = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", 0, {12'h0, flags}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    send(3'b000, 4'd12, 16'h7FFF, 16'h0001, 1'b0);
    send(3'b000, 4'd14, 16'h0005, 16'h0005, 1'b0);
    send(3'b000, 4'd14, 16'h0003, 16'h0005, 1'b0);
    send(3'b000, 4'd12, 16'hFFFF, 16'h0001, 1'b0);
    send(3'b000, 4'd13, 16'h0000, 16'h0000, 1'b0);
    send(3'b000, 4'd7,  16'h8001, 16'h0001, 1'b0);
    send(3'b001, 4'd9,  16'h8000, 16'h000F, 1'b0);
    send(3'b000, 4'd11, 16'h0001, 16'h0001, 1'b0);
    send(3'b000, 4'd8,  16'hABCD, 16'hFFF0, 1'b0);
    send(3'b000, 4'd14, 16'h0000, 16'h0000, 1'b1);
    send(3'b100, 4'd14, 16'h1000, 16'h0004, 1'b0);
    send(3'b011, 4'd0,  16'h1200, 16'h0034, 1'b0);
    send(3'b000, 4'd15, 16'h0000, 16'h0001, 1'b0);
    send(3'b000, 4'd15, 16'h0000, 16'h0000, 1'b0);

    for (int i = 0; i < 600; i++)
      send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), pick_val(), pick_val(),
           ($urandom_range(0, 3) == 0));
    drain();

    send(3'b000, 4'd12, 16'h7FFF, 16'h0001, 1'b0);
    send(3'b100, 4'd0,  16'h0000, 16'h0000, 1'b0);
    drain();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_flags = 4'h0;
    #1;
    check("async_reset_flags", next_id, {12'h0, flags}, 16'h0000);
    lhs = 16'h1234; rhs = 16'h0001;
    #1;
    check("reset_result", next_id, result, 16'h1235);
    @(posedge clk);
    #1;
    check("reset_hold_flags", next_id, {12'h0, flags}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    send(3'b000, 4'd13, 16'h0001, 16'h0001, 1'b0);
    for (int i = 0; i < 100; i++)
      send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), pick_val(), pick_val(),
           ($urandom_range(0, 3) == 0));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
